// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR request sequencer: FSM encoding and counter width.
package sr_ctrl_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser, debounce counter and rising-edge detector for one raw request level.
module debounce_filter
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw_in,
    output logic filt_out,
    output logic rise_out
);

    // Compare value: the filtered level flips on the DEBOUNCE_CYCLES-th mismatching sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q,  filt_d;
    logic             rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchroniser shift, debounce count and registered rising-edge pulse.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                rise_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_out = filt_q;
    assign rise_out = rise_q;

endmodule

// File: rtl/sr_request_sequencer.sv
// Turns debounced set/clear request edges into single-cycle, mutually exclusive S/R pulses.
module sr_request_sequencer
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic SetReq,
    input  logic ClrReq,
    output logic S,
    output logic R,
    output logic Busy,
    output logic Conflict
);

    // Last holdoff count value; unused when HOLDOFF_CYCLES is zero.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

    logic set_lvl, set_rise;
    logic clr_lvl, clr_rise;
    logic set_edge, clr_edge;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             set_pend_q, set_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic             order_q,    order_d;     // 1: clear request is the older one
    logic             conflict_q, conflict_d;
    logic             s_q,        s_d;
    logic             r_q,        r_d;
    logic             busy_q,     busy_d;
    logic             take_set,   take_clr;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_filter (
        .Clock    (Clock),
        .Reset    (Reset),
        .raw_in   (SetReq),
        .filt_out (set_lvl),
        .rise_out (set_rise)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_filter (
        .Clock    (Clock),
        .Reset    (Reset),
        .raw_in   (ClrReq),
        .filt_out (clr_lvl),
        .rise_out (clr_rise)
    );

    // An edge only counts while the settled level agrees with it.
    assign set_edge = set_rise & set_lvl;
    assign clr_edge = clr_rise & clr_lvl;

    // Next-state, pending-flag, order and output decode.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        set_pend_d = set_pend_q;
        clr_pend_d = clr_pend_q;
        order_d    = order_q;
        conflict_d = set_edge & clr_edge;
        take_set   = 1'b0;
        take_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (set_pend_q && (!clr_pend_q || !order_q)) begin
                    state_d  = PULSE_S;
                    take_set = 1'b1;
                end else if (clr_pend_q) begin
                    state_d  = PULSE_R;
                    take_clr = 1'b1;
                end
            end
            PULSE_S, PULSE_R: begin
                hold_cnt_d = '0;
                state_d    = (HOLDOFF_CYCLES > 0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        if (take_set) set_pend_d = 1'b0;
        if (take_clr) clr_pend_d = 1'b0;

        // Simultaneous edges are discarded; an already pending channel absorbs further edges.
        if (!conflict_d) begin
            if (set_edge && !set_pend_q) set_pend_d = 1'b1;
            if (clr_edge && !clr_pend_q) clr_pend_d = 1'b1;
        end

        // With a single request pending, it is by definition the older one.
        if (set_pend_d && !clr_pend_d) begin
            order_d = 1'b0;
        end else if (clr_pend_d && !set_pend_d) begin
            order_d = 1'b1;
        end

        s_d    = (state_d == PULSE_S);
        r_d    = (state_d == PULSE_R);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops S/R without waiting for a clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            order_q    <= 1'b0;
            conflict_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
            order_q    <= order_d;
            conflict_q <= conflict_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign Busy     = busy_q;
    assign Conflict = conflict_q;

endmodule

// File: doc/sr_request_sequencer.md
Name: sr_request_sequencer

Overview:
Upstream driver for the sr_flipflop stage. It takes two raw, bouncy request levels (set and clear), synchronises and debounces them, and converts each debounced rising edge into exactly one single-cycle S or R pulse. S and R are never high together, so the flip-flop never sees the illegal S=R=1 input. Its S and R outputs connect directly to the flip-flop's S and R inputs, and both blocks share Clock.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the filtered level changes (legal range 1..255)
HOLDOFF_CYCLES, 2, idle cycles forced after each output pulse before the next pulse may issue (legal range 0..255)

Ports:
Clock    input   1  rising-edge clock, shared with sr_flipflop
Reset    input   1  asynchronous, active-high; clears all state
SetReq   input   1  raw set request level (asynchronous to Clock, may bounce)
ClrReq   input   1  raw clear request level (asynchronous to Clock, may bounce)
S        output  1  registered set pulse to the flip-flop
R        output  1  registered reset pulse to the flip-flop
Busy     output  1  high whenever the FSM is not in IDLE
Conflict output  1  one-cycle flag: simultaneous set and clear requests were discarded

Behaviour:
- Reset (async, active-high): S=0, R=0, Busy=0, Conflict=0, FSM=IDLE. Synchronisers, filtered levels, counters, pending flags and the order bit all clear. Reset asserted mid-pulse or mid-holdoff drops S/R immediately, without waiting for a clock edge.
- Synchroniser: a 2-flop synchroniser on each of SetReq and ClrReq.
- Debounce, per channel:
  - Counter increments while the synchronised level differs from the filtered level.
  - Counter clears whenever the two levels match.
  - When the count reaches DEBOUNCE_CYCLES, the filtered level takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES produce no output.
- Edge capture:
  - A filtered rising edge sets that channel's pending flag. Falling edges are ignored.
  - Each channel holds at most one pending request; further edges while already pending are absorbed.
  - An order bit records which flag was set first.
  - Rising edges on both channels in the same cycle: neither flag is set, and Conflict=1 in the next cycle.
- FSM states: IDLE, PULSE_S, PULSE_R, HOLDOFF.
  - IDLE -> PULSE_S if set is pending and is the older (or only) request; the set flag clears.
  - IDLE -> PULSE_R under the same rule for clear.
  - PULSE_S: S=1 for exactly one cycle. PULSE_R: R=1 for exactly one cycle.
  - PULSE_S/PULSE_R -> HOLDOFF if HOLDOFF_CYCLES>0, otherwise -> IDLE.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then -> IDLE. Requests arriving during a pulse or holdoff stay pending and are served afterwards in arrival order.
- Latency: with the raw level held high, S (or R) is high during the cycle after edge 3+DEBOUNCE_CYCLES, where edge 0 is the first edge that samples the raw high. For DEBOUNCE_CYCLES=4 this is edge 7. The latency is exact, not a bound.
- Invariants:
  - S and R are never both 1.
  - Each pulse is exactly one cycle wide.
  - Two pulses are always separated by at least HOLDOFF_CYCLES low cycles.
  - Busy = (state != IDLE), registered with the state.
- Counter widths: 8 bits, no wrap. Each counter saturates at its compare value and clears.

Decomposition:
- Shared package sr_ctrl_pkg holds:
  - FSM state encoding: IDLE=2'd0, PULSE_S=2'd1, PULSE_R=2'd2, HOLDOFF=2'd3.
  - Counter width constant CNT_W=8.
- One sub-module, debounce_filter (parameter DEBOUNCE_CYCLES; ports Clock, Reset, raw in, filtered out, rise pulse out), contains the synchroniser, debounce counter and edge detector. It is instantiated twice, once for SetReq and once for ClrReq.
- The FSM, pending flags, order bit and holdoff counter live in the top module.

Test Plan:
- Reset then idle: Reset=1 for 3 cycles, release, inputs low for 20 cycles -> S=R=Busy=Conflict=0 throughout; asserting Reset mid-pulse drives S to 0 immediately.
- Clean set (defaults): SetReq 0->1 held -> S=1 for exactly the cycle after edge 7; R stays 0; Busy high for 1+2 cycles; a second S pulse only after SetReq falls and rises again.
- Bounce rejection: SetReq pulses high for 2 cycles 5 times, with gaps of 2 -> no S pulse; then held high 10 cycles -> exactly one S pulse.
- Ordering: ClrReq rises, SetReq rises 1 cycle later -> R pulse, 2 holdoff cycles, then S pulse; the two are never high together and never adjacent.
- Simultaneous: SetReq and ClrReq rise on the same edge, held -> Conflict=1 for exactly 1 cycle, no S or R pulse, FSM stays IDLE.
- Chain with sr_flipflop: set, then clear, then set sequence -> flip-flop Q=1, 0, 1 with QBar complementary after each pulse.
